// File: rtl/markov_song_generator.sv
// Streams a song by drawing count-weighted sequences from a latched Markov table
// and emitting their notes over a valid/ready handshake.
module markov_song_generator #(
    parameter int unsigned NOTE_BIT_LEN     = 7,
    parameter int unsigned DELAY_BIT_LEN    = 8,
    parameter int unsigned SEQUENCE_LEN     = 4,
    parameter int unsigned SEQ_CNT_BIT_LEN  = 8,
    parameter int unsigned MARKOV_CHAIN_LEN = 16,
    parameter int unsigned SONG_OUTPUT_LEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [15:0]              seed,
    input  logic [(SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)+SEQ_CNT_BIT_LEN)
                  *MARKOV_CHAIN_LEN-1:0] markov,
    output logic [NOTE_BIT_LEN-1:0]  note_out,
    output logic [DELAY_BIT_LEN-1:0] delay_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     empty_err
);

    localparam int unsigned ElemW  = NOTE_BIT_LEN + DELAY_BIT_LEN;
    localparam int unsigned EntryW = SEQUENCE_LEN * ElemW + SEQ_CNT_BIT_LEN;
    localparam int unsigned TableW = EntryW * MARKOV_CHAIN_LEN;
    localparam int unsigned CntW   = SEQ_CNT_BIT_LEN;
    localparam int unsigned IdxW   = $clog2(MARKOV_CHAIN_LEN);
    localparam int unsigned TotW   = CntW + IdxW;
    localparam int unsigned ElW    = (SEQUENCE_LEN > 1) ? $clog2(SEQUENCE_LEN) : 1;
    localparam int unsigned NumW   = $clog2(SONG_OUTPUT_LEN + 1);
    localparam logic [15:0] LfsrDefault = 16'hACE1;
    localparam logic [15:0] LfsrTaps    = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StSum,
        StDraw,
        StScan,
        StEmit,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic [TableW-1:0]   table_q, table_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [TotW-1:0]     total_q, total_d;
    logic [TotW-1:0]     mask_q, mask_d;
    logic [TotW-1:0]     r_q, r_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [ElW-1:0]      elem_q, elem_d;
    logic [NumW-1:0]     num_q, num_d;
    logic                done_q, done_d;
    logic                empty_q, empty_d;

    logic [CntW-1:0]     cur_cnt;
    logic [TotW-1:0]     cur_cnt_ext;
    logic [ElemW-1:0]    cur_elem;
    logic [TotW-1:0]     sum_next;
    logic [TotW-1:0]     draw_r;
    logic [15:0]         lfsr_next;

    // Smears the highest set bit downward: smallest 2^k-1 that covers v.
    function automatic logic [TotW-1:0] fill_mask(input logic [TotW-1:0] v);
        logic [TotW-1:0] m;
        m = v;
        for (int s = 0; s < int'(TotW); s++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

    assign cur_cnt     = table_q[32'(idx_q) * EntryW + SEQUENCE_LEN * ElemW +: CntW];
    assign cur_cnt_ext = {{(TotW - CntW){1'b0}}, cur_cnt};
    assign cur_elem    = table_q[32'(idx_q) * EntryW + 32'(elem_q) * ElemW +: ElemW];
    assign sum_next    = total_q + cur_cnt_ext;
    assign draw_r      = lfsr_q[TotW-1:0] & mask_q;
    assign lfsr_next   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        lfsr_d  = lfsr_q;
        total_d = total_q;
        mask_d  = mask_q;
        r_d     = r_q;
        idx_d   = idx_q;
        elem_d  = elem_q;
        num_d   = num_q;
        done_d  = done_q;
        empty_d = empty_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    table_d = markov;
                    lfsr_d  = (seed == 16'h0000) ? LfsrDefault : seed;
                    done_d  = 1'b0;
                    empty_d = 1'b0;
                    num_d   = '0;
                    total_d = '0;
                    idx_d   = '0;
                    state_d = StSum;
                end
            end
            StSum: begin
                total_d = sum_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IdxW'(MARKOV_CHAIN_LEN - 1)) begin
                    mask_d = fill_mask(sum_next - 1'b1);
                    if (sum_next == '0) begin
                        empty_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        state_d = StDraw;
                    end
                end
            end
            StDraw: begin
                lfsr_d = lfsr_next;
                // Out-of-range samples are rejected so every count unit is equally likely.
                if (draw_r < total_q) begin
                    r_d     = draw_r;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (r_q < cur_cnt_ext) begin
                    elem_d  = '0;
                    state_d = StEmit;
                end else begin
                    r_d   = r_q - cur_cnt_ext;
                    idx_d = idx_q + 1'b1;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    num_d = num_q + 1'b1;
                    if (num_q == NumW'(SONG_OUTPUT_LEN - 1)) begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else if (elem_q == ElW'(SEQUENCE_LEN - 1)) begin
                        state_d = StDraw;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            table_q <= '0;
            lfsr_q  <= LfsrDefault;
            total_q <= '0;
            mask_q  <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            elem_q  <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            lfsr_q  <= lfsr_d;
            total_q <= total_d;
            mask_q  <= mask_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            num_q   <= num_d;
            done_q  <= done_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StEmit);
        note_out  = out_valid ? cur_elem[ElemW-1 -: NOTE_BIT_LEN] : '0;
        delay_out = out_valid ? cur_elem[DELAY_BIT_LEN-1:0] : '0;
        busy      = (state_q == StSum) || (state_q == StDraw) || (state_q == StScan) ||
                    (state_q == StEmit);
        done      = done_q;
        empty_err = empty_q;
    end

endmodule

// File: doc/markov_song_generator.md
# markov_song_generator

Downstream consumer of the Markov learning stage. It latches the flat Markov table (sequence + occurrence count per entry) when `start` is asserted. It then repeatedly draws an entry at random, weighted by count, using an internal LFSR. Each drawn sequence is streamed out note-by-note over a valid/ready handshake until `SONG_OUTPUT_LEN` notes have been emitted.

## Interface
- `NOTE_BIT_LEN`, 7, note field width
- `DELAY_BIT_LEN`, 8, delay field width
- `SEQUENCE_LEN`, 4, notes per table sequence
- `SEQ_CNT_BIT_LEN`, 8, count field width
- `MARKOV_CHAIN_LEN`, 16, table entries (power of two)
- `SONG_OUTPUT_LEN`, 32, notes generated per run
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  one-cycle request; ignored while `busy`
- `seed`  in  16  LFSR seed, sampled with `start`
- `markov`  in  (SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)+SEQ_CNT_BIT_LEN)*MARKOV_CHAIN_LEN  table, sampled with `start`
- `note_out`  out  NOTE_BIT_LEN  emitted note
- `delay_out`  out  DELAY_BIT_LEN  emitted delay
- `out_valid`  out  1  note/delay valid
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `busy`  out  1  high from the cycle after accepted `start` until FINISH
- `done`  out  1  level; high in FINISH, cleared by next accepted `start`
- `empty_err`  out  1  set with `done` when table total count is 0

## Operation
- Field layout:
  - W = NOTE+DELAY.
  - E = SEQUENCE_LEN*W + SEQ_CNT_BIT_LEN.
  - Entry e occupies `markov[e*E +: E]`, with the count in its top SEQ_CNT_BIT_LEN bits.
  - Element k of an entry occupies bits `[k*W +: W]`, with the note in the upper bits and the delay in the lower bits.
  - Element 0 is emitted first.
- LFSR: 16-bit Galois, shifts right, XOR mask 0xB400 applied when the shifted-out bit is 1. A seed of 0 loads 0xACE1.
- States: IDLE, SUM, DRAW, SCAN, EMIT, FINISH.
- IDLE: on `start`, latch the table and seed; clear `done`/`empty_err` and the note counter; go to SUM.
- SUM:
  - Accumulate one entry count per cycle into `total`. Width TW = SEQ_CNT_BIT_LEN + log2(MARKOV_CHAIN_LEN); no overflow is possible.
  - After the last entry, compute `mask` = smallest 2^k-1 >= total-1.
  - If total=0, go to FINISH with `empty_err`=1; otherwise go to DRAW.
- DRAW:
  - r = lfsr[TW-1:0] & mask, then advance the LFSR.
  - If r >= total, stay in DRAW (rejection resample).
  - Otherwise set scan index i=0 and go to SCAN.
- SCAN: one entry per cycle.
  - If r < count(i), select i and go to EMIT with element index j=0.
  - Otherwise r -= count(i) and i++.
  - Zero-count entries are always skipped. i never exceeds MARKOV_CHAIN_LEN-1 because r < total.
- EMIT:
  - `out_valid`=1 with element j of entry i; hold values stable until the handshake.
  - On handshake: increment the note counter.
  - If the counter reaches SONG_OUTPUT_LEN, go to FINISH. This truncates mid-sequence if needed.
  - Else if j = SEQUENCE_LEN-1, go to DRAW.
  - Else j++.
- FINISH: `done`=1; go to IDLE in the same cycle. `done` stays high in IDLE until the next accepted `start`.
- Output reset values: `note_out`=0, `delay_out`=0, `out_valid`=0, `busy`=0, `done`=0, `empty_err`=0. State resets to IDLE and the LFSR to 0xACE1.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. No partial handshake completes.

## Timing
- SUM always takes exactly MARKOV_CHAIN_LEN cycles.
- DRAW takes 1 cycle per attempt.
- SCAN takes (selected index + 1) cycles.
- EMIT takes at least 1 cycle per note; back-to-back notes within a sequence issue on consecutive cycles when `out_ready`=1.
- First `out_valid` appears at least 1 + MARKOV_CHAIN_LEN + 1 + 1 cycles after `start`.
- `out_ready` may toggle freely; `out_valid` never drops without a handshake.
- `start` while `busy` is ignored; the table is not re-latched.

## Test plan
- Single nonzero entry: entry 5 count=3, all others 0, elements notes 10,11,12,13 with delays 1,2,3,4 -> output repeats (10,1),(11,2),(12,3),(13,4) eight times, then `done`=1, `empty_err`=0.
- All counts 0 -> `done`=1 and `empty_err`=1 exactly 17 cycles after `start`; `out_valid` is never asserted.
- Weighted draw: entry 0 count=1, entry 1 count=3, seed=0x1234, 1000 runs across seeds -> entry 1 chosen in 75% ±5% of draws; selections match the bench LFSR model cycle-exactly.
- Backpressure: `out_ready` random at 30% -> the same note stream as with `out_ready`=1, and `note_out`/`delay_out` stable while `out_valid & !out_ready`.
- Truncation: SEQUENCE_LEN=4 with SONG_OUTPUT_LEN=30 -> exactly 30 handshakes; the final sequence stops after its 2nd element.
- Reset while in EMIT -> the next cycle has `out_valid`=0, `busy`=0, `done`=0; a new `start` then produces the seed-determined stream from the beginning.
